// File: rtl/alu_8bit_pkg.sv
// Shared opcode encodings, instruction field positions and the result payload
// for the 8-bit calculator ALU.
package alu_8bit_pkg;

    localparam int unsigned DATA_W  = 8;
    localparam int unsigned OPC_W   = 2;
    localparam int unsigned INSTR_W = OPC_W + 2 * DATA_W;

    localparam logic [OPC_W-1:0] OP_ADD = 2'b00;
    localparam logic [OPC_W-1:0] OP_SUB = 2'b01;
    localparam logic [OPC_W-1:0] OP_MUL = 2'b10;
    localparam logic [OPC_W-1:0] OP_DIV = 2'b11;

    localparam int unsigned OPC_MSB = 17;
    localparam int unsigned OPC_LSB = 16;
    localparam int unsigned A_MSB   = 15;
    localparam int unsigned A_LSB   = 8;
    localparam int unsigned B_MSB   = 7;
    localparam int unsigned B_LSB   = 0;

    typedef struct packed {
        logic [DATA_W-1:0] out;
        logic [DATA_W-1:0] ext;
        logic              overflow;
        logic              carry;
    } alu_result_t;

endpackage

// File: rtl/alu_8bit_if.sv
// Instruction/result bundle between the calculator sequencer and the ALU.
interface alu_8bit_if;
    import alu_8bit_pkg::*;

    logic [INSTR_W-1:0] instruction;
    logic [DATA_W-1:0]  out;
    logic [DATA_W-1:0]  extended_out;
    logic               overflow;
    logic               carry;

    modport master (
        output instruction,
        input  out,
        input  extended_out,
        input  overflow,
        input  carry
    );

    modport slave (
        input  instruction,
        output out,
        output extended_out,
        output overflow,
        output carry
    );
endinterface

// File: rtl/alu_8bit_divider.sv
// Combinational 8-bit unsigned restoring divider. A zero divisor naturally
// yields quotient 0xFF and remainder = dividend; div_by_zero flags that case.
module alu_8bit_divider
    import alu_8bit_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] quotient,
    output logic [DATA_W-1:0] remainder,
    output logic              div_by_zero
);

    logic [DATA_W:0] partial;

    // One restoring step per dividend bit, MSB first; partial stays below 2*b.
    always_comb begin
        partial  = '0;
        quotient = '0;
        for (int i = DATA_W - 1; i >= 0; i--) begin
            partial = {partial[DATA_W-1:0], a[i]};
            if (partial >= {1'b0, b}) begin
                partial     = partial - {1'b0, b};
                quotient[i] = 1'b1;
            end
        end
    end

    assign remainder   = partial[DATA_W-1:0];
    assign div_by_zero = (b == '0);

endmodule

// File: rtl/alu_8bit.sv
// 8-bit unsigned calculator ALU: decodes one instruction per clock and
// registers out / extended_out / overflow / carry with async active-high reset.
module alu_8bit
    import alu_8bit_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    alu_8bit_if.slave  bus
);

    logic [OPC_W-1:0]    opcode;
    logic [DATA_W-1:0]   a;
    logic [DATA_W-1:0]   b;
    logic [DATA_W:0]     sum;
    logic [DATA_W:0]     diff;
    logic [2*DATA_W-1:0] prod;
    logic [DATA_W-1:0]   quotient;
    logic [DATA_W-1:0]   remainder;
    logic                div_by_zero;
    alu_result_t         res_d;
    alu_result_t         res_q;

    assign opcode = bus.instruction[OPC_MSB:OPC_LSB];
    assign a      = bus.instruction[A_MSB:A_LSB];
    assign b      = bus.instruction[B_MSB:B_LSB];

    // diff[8] is the borrow, set exactly when a < b.
    assign sum  = {1'b0, a} + {1'b0, b};
    assign diff = {1'b0, a} - {1'b0, b};
    assign prod = (2*DATA_W)'(a) * (2*DATA_W)'(b);

    alu_8bit_divider u_divider (
        .a           (a),
        .b           (b),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    // Next-result select; every field defaults to zero.
    always_comb begin
        res_d = '0;
        unique case (opcode)
            OP_ADD: begin
                res_d.out      = sum[DATA_W-1:0];
                res_d.carry    = sum[DATA_W];
                res_d.overflow = (a[DATA_W-1] == b[DATA_W-1]) &&
                                 (sum[DATA_W-1] != a[DATA_W-1]);
            end
            OP_SUB: begin
                res_d.out      = diff[DATA_W-1:0];
                res_d.carry    = diff[DATA_W];
                res_d.overflow = (a[DATA_W-1] != b[DATA_W-1]) &&
                                 (diff[DATA_W-1] != a[DATA_W-1]);
            end
            OP_MUL: begin
                res_d.out      = prod[DATA_W-1:0];
                res_d.ext      = prod[2*DATA_W-1:DATA_W];
                res_d.carry    = (prod[2*DATA_W-1:DATA_W] != '0);
                res_d.overflow = (prod[2*DATA_W-1:DATA_W] != '0);
            end
            OP_DIV: begin
                if (div_by_zero) begin
                    res_d.out      = '1;
                    res_d.ext      = a;
                    res_d.overflow = 1'b1;
                end else begin
                    res_d.out = quotient;
                    res_d.ext = remainder;
                end
            end
            default: res_d = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_q <= '0;
        end else begin
            res_q <= res_d;
        end
    end

    assign bus.out          = res_q.out;
    assign bus.extended_out = res_q.ext;
    assign bus.overflow     = res_q.overflow;
    assign bus.carry        = res_q.carry;

endmodule

// File: tb/tb_alu_8bit.sv
// Self-checking bench for alu_8bit: directed vector table, reset sequences and
// random instructions checked against an arithmetic reference model.
module tb_alu_8bit;

    typedef struct {
        logic [17:0] instr;
        logic [7:0]  out;
        logic [7:0]  ext;
        logic        c;
        logic        v;
    } vec_t;

    logic clk;
    logic rst;
    int   errors;
    int   checks;

    alu_8bit_if bus ();

    alu_8bit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int sval(int x);
        return (x >= 128) ? x - 256 : x;
    endfunction

    // Reference: plain integer arithmetic from the operation definitions.
    function automatic logic [17:0] model(logic [17:0] ins);
        int op, a, b, r, s;
        logic [7:0] o, e;
        logic c, v;
        op = int'(ins[17:16]);
        a  = int'(ins[15:8]);
        b  = int'(ins[7:0]);
        o = 8'h00; e = 8'h00; c = 1'b0; v = 1'b0;
        case (op)
            0: begin
                r = a + b;
                o = 8'(r % 256);
                c = (r > 255);
                s = sval(a) + sval(b);
                v = (s > 127) || (s < -128);
            end
            1: begin
                r = a - b;
                o = 8'((r + 256) % 256);
                c = (a < b);
                s = sval(a) - sval(b);
                v = (s > 127) || (s < -128);
            end
            2: begin
                r = a * b;
                o = 8'(r % 256);
                e = 8'(r / 256);
                c = (r > 255);
                v = (r > 255);
            end
            default: begin
                if (b == 0) begin
                    o = 8'hFF; e = 8'(a); v = 1'b1;
                end else begin
                    o = 8'(a / b); e = 8'(a % b);
                end
            end
        endcase
        return {o, e, c, v};
    endfunction

    task automatic check(input string name, input logic [17:0] exp);
        logic [17:0] got;
        got = {bus.out, bus.extended_out, bus.carry, bus.overflow};
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got out=%h ext=%h c=%b v=%b, want out=%h ext=%h c=%b v=%b",
                     name, got[17:10], got[9:2], got[1], got[0],
                     exp[17:10], exp[9:2], exp[1], exp[0]);
        end
    endtask

    task automatic apply(input logic [17:0] ins);
        @(negedge clk);
        bus.instruction = ins;
        @(posedge clk);
        #1;
    endtask

    vec_t vecs[$];

    initial begin
        errors = 0;
        checks = 0;
        vecs = '{
            '{18'b00_00000001_00000001, 8'h02, 8'h00, 1'b0, 1'b0},
            '{18'b01_00010100_00001111, 8'h05, 8'h00, 1'b0, 1'b0},
            '{{2'b00, 8'h7F, 8'h01},    8'h80, 8'h00, 1'b0, 1'b1},
            '{{2'b00, 8'hFF, 8'h01},    8'h00, 8'h00, 1'b1, 1'b0},
            '{{2'b01, 8'h00, 8'h01},    8'hFF, 8'h00, 1'b1, 1'b0},
            '{{2'b01, 8'h80, 8'h01},    8'h7F, 8'h00, 1'b0, 1'b1},
            '{{2'b10, 8'h03, 8'h03},    8'h09, 8'h00, 1'b0, 1'b0},
            '{{2'b10, 8'hFF, 8'hFF},    8'h01, 8'hFE, 1'b1, 1'b1},
            '{18'b11_00000011_00000011, 8'h01, 8'h00, 1'b0, 1'b0},
            '{{2'b11, 8'h14, 8'h06},    8'h03, 8'h02, 1'b0, 1'b0},
            '{{2'b11, 8'h14, 8'h00},    8'hFF, 8'h14, 1'b0, 1'b1},
            '{{2'b11, 8'h03, 8'h03},    8'h01, 8'h00, 1'b0, 1'b0},
            '{{2'b11, 8'hFF, 8'h01},    8'hFF, 8'h00, 1'b0, 1'b0}
        };

        // Reset applied before any clock edge.
        rst = 1'b1;
        bus.instruction = {2'b10, 8'hFF, 8'hFF};
        #2;
        check("reset_before_edge", 18'h0);
        @(posedge clk);
        #1;
        check("reset_holds_over_edge", 18'h0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i].instr);
            check($sformatf("vec[%0d]", i),
                  {vecs[i].out, vecs[i].ext, vecs[i].c, vecs[i].v});
        end

        // Async reset mid-stream while outputs are non-zero.
        apply({2'b10, 8'hFF, 8'hFF});
        check("pre_async_reset", {8'h01, 8'hFE, 1'b1, 1'b1});
        #1;
        rst = 1'b1;
        #1;
        check("async_reset_no_edge", 18'h0);
        bus.instruction = {2'b00, 8'h7F, 8'h01};
        @(posedge clk);
        #1;
        check("async_reset_holds", 18'h0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("first_edge_after_release", {8'h80, 8'h00, 1'b0, 1'b1});

        // Random back-to-back instructions against the model.
        for (int i = 0; i < 400; i++) begin
            logic [17:0] ins;
            ins = 18'($urandom);
            if (i % 16 == 0) ins[7:0] = 8'h00;
            apply(ins);
            check($sformatf("rand[%0d] instr=%h", i, ins), model(ins));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
